// File: rtl/pkg_opengpu.sv
// ============================================================================
// Module : pkg_opengpu
// Brief  : Shared FPU types and floating-point format constants.
// Rev    : 1.0  initial int-to-float additions
// ============================================================================
`default_nettype none

package pkg_opengpu;

    localparam int DATA_WIDTH    = 32;
    localparam int FP_EXP_WIDTH  = 8;
    localparam int FP_MANT_WIDTH = 23;
    localparam int FP_EXP_BIAS   = 127;

    typedef enum logic [3:0] {
        FPU_ADD     = 4'd0,
        FPU_SUB     = 4'd1,
        FPU_MUL     = 4'd2,
        FPU_CMP     = 4'd3,
        FPU_CVT_F2I = 4'd4,
        FPU_CVT_I2F = 4'd5,
        FPU_CVT_U2F = 4'd6
    } fpu_op_t;

    typedef enum logic [1:0] {
        I2F_IDLE  = 2'd0,
        I2F_NORM  = 2'd1,
        I2F_ROUND = 2'd2,
        I2F_DONE  = 2'd3
    } i2f_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ============================================================================
// Module : fp_round_rne
// Brief  : Round-to-nearest-even of a normalised magnitude into exp/fraction.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module fp_round_rne
    import pkg_opengpu::*;
(
    input  logic [DATA_WIDTH-1:0]                 mag,
    input  logic [FP_EXP_WIDTH-1:0]               exp_in,
    output logic [FP_EXP_WIDTH+FP_MANT_WIDTH-1:0] exp_frac,
    output logic                                  inexact
);

    localparam int GUARD_BIT = DATA_WIDTH - FP_MANT_WIDTH - 2;

    logic                      guard;
    logic                      sticky;
    logic                      lsb;
    logic                      round_up;
    logic [FP_MANT_WIDTH:0]    frac_sum;
    logic [FP_EXP_WIDTH-1:0]   exp_out;
    logic [FP_MANT_WIDTH-1:0]  frac_out;
    // The leading one is implicit in the packed format.
    logic                      unused_lead;

    assign unused_lead = mag[DATA_WIDTH-1];
    assign guard       = mag[GUARD_BIT];
    assign sticky      = |mag[GUARD_BIT-1:0];
    assign lsb         = mag[GUARD_BIT+1];
    assign round_up    = guard & (sticky | lsb);
    assign frac_sum    = {1'b0, mag[DATA_WIDTH-2:GUARD_BIT+1]}
                       + {{FP_MANT_WIDTH{1'b0}}, round_up};

    always_comb begin
        exp_out  = exp_in;
        frac_out = frac_sum[FP_MANT_WIDTH-1:0];
        if (frac_sum[FP_MANT_WIDTH]) begin
            exp_out  = exp_in + 1'b1;
            frac_out = '0;
        end
    end

    assign exp_frac = {exp_out, frac_out};
    assign inexact  = guard | sticky;

endmodule

`default_nettype wire

// File: rtl/fp_int_to_float.sv
// ============================================================================
// Module : fp_int_to_float
// Brief  : Iterative FCVT.S.W / FCVT.S.WU converter with valid/ready handshake.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module fp_int_to_float
    import pkg_opengpu::*;
#(
    parameter int TAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand,
    input  fpu_op_t               fpu_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  flag_inexact
);

    localparam logic [FP_EXP_WIDTH-1:0] EXP_START = FP_EXP_WIDTH'(FP_EXP_BIAS + 31);

    i2f_state_t                        state;
    fpu_op_t                           op_q;
    logic                              sign_q;
    logic [DATA_WIDTH-1:0]             mag_q;
    logic [FP_EXP_WIDTH-1:0]           exp_q;

    logic                              accept;
    logic                              is_signed;
    logic                              supported;
    logic [DATA_WIDTH-1:0]             in_mag;
    logic [FP_EXP_WIDTH+FP_MANT_WIDTH-1:0] rnd_exp_frac;
    logic                              rnd_inexact;

    assign in_ready  = (state == I2F_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == I2F_DONE);

    assign is_signed = (fpu_op == FPU_CVT_I2F);
    assign supported = is_signed || (fpu_op == FPU_CVT_U2F);
    // Negating INT_MIN wraps back to 0x80000000, which is the correct magnitude.
    assign in_mag    = (is_signed && operand[DATA_WIDTH-1]) ? (~operand + 1'b1) : operand;

    fp_round_rne u_round (
        .mag      (mag_q),
        .exp_in   (exp_q),
        .exp_frac (rnd_exp_frac),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= I2F_IDLE;
            op_q         <= FPU_ADD;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            exp_q        <= '0;
            result       <= '0;
            out_tag      <= '0;
            flag_inexact <= 1'b0;
        end else begin
            case (state)
                I2F_IDLE: begin
                    if (accept) begin
                        op_q    <= fpu_op;
                        sign_q  <= operand[DATA_WIDTH-1];
                        mag_q   <= in_mag;
                        exp_q   <= EXP_START;
                        out_tag <= in_tag;
                        if (!supported || (in_mag == '0)) begin
                            result       <= '0;
                            flag_inexact <= 1'b0;
                            state        <= I2F_DONE;
                        end else begin
                            state <= I2F_NORM;
                        end
                    end
                end
                I2F_NORM: begin
                    if (mag_q[DATA_WIDTH-1]) begin
                        state <= I2F_ROUND;
                    end else if (mag_q[DATA_WIDTH-1 -: 4] == 4'd0) begin
                        mag_q <= mag_q << 4;
                        exp_q <= exp_q - FP_EXP_WIDTH'(4);
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - FP_EXP_WIDTH'(1);
                    end
                end
                I2F_ROUND: begin
                    result       <= {sign_q && (op_q == FPU_CVT_I2F), rnd_exp_frac};
                    flag_inexact <= rnd_inexact;
                    state        <= I2F_DONE;
                end
                I2F_DONE: begin
                    if (out_ready) begin
                        state <= I2F_IDLE;
                    end
                end
                default: state <= I2F_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_int_to_float.sv
// ============================================================================
// Module : tb_fp_int_to_float
// Brief  : Directed self-checking bench for fp_int_to_float.
// Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module tb_fp_int_to_float;
    import pkg_opengpu::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand = '0;
    fpu_op_t     fpu_op = FPU_CVT_I2F;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        flag_inexact;

    int checks   = 0;
    int failures = 0;
    int lat;

    fp_int_to_float #(.TAG_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operand      (operand),
        .fpu_op       (fpu_op),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_tag      (out_tag),
        .flag_inexact (flag_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid; lat counts 1 for the cycle right after the accept edge.
    task automatic wait_out();
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic start(input fpu_op_t op, input logic [31:0] opnd, input logic [4:0] tag);
        int guard_cnt = 0;
        while (!in_ready && guard_cnt < 40) begin
            tick();
            guard_cnt++;
        end
        fpu_op   = op;
        operand  = opnd;
        in_tag   = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic conv(input string name, input fpu_op_t op, input logic [31:0] opnd,
                        input logic [4:0] tag, input logic [31:0] exp_res,
                        input logic exp_inx, input int exp_lat);
        start(op, opnd, tag);
        wait_out();
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, result, exp_res);
        chk({name, "_inx"}, {31'd0, flag_inexact}, {31'd0, exp_inx});
        chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
        handshake();
    endtask

    initial begin
        logic [31:0] held_res;
        tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_inx", {31'd0, flag_inexact}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        conv("s_one",    FPU_CVT_I2F, 32'd1,        5'd1,  32'h3F800000, 1'b0, 13);
        conv("s_mone",   FPU_CVT_I2F, 32'hFFFFFFFF, 5'd2,  32'hBF800000, 1'b0, 13);
        conv("s_zero",   FPU_CVT_I2F, 32'd0,        5'd3,  32'h00000000, 1'b0, 1);
        conv("s_min",    FPU_CVT_I2F, 32'h80000000, 5'd4,  32'hCF000000, 1'b0, 3);
        conv("s_max",    FPU_CVT_I2F, 32'h7FFFFFFF, 5'd5,  32'h4F000000, 1'b1, 4);
        conv("u_max",    FPU_CVT_U2F, 32'hFFFFFFFF, 5'd6,  32'h4F800000, 1'b1, 3);
        conv("u_msb",    FPU_CVT_U2F, 32'h80000000, 5'd7,  32'h4F000000, 1'b0, 3);
        conv("tie_lo",   FPU_CVT_I2F, 32'd16777217, 5'd8,  32'h4B800000, 1'b1, 7);
        conv("tie_up",   FPU_CVT_I2F, 32'd16777219, 5'd9,  32'h4B800002, 1'b1, 7);
        conv("exact24",  FPU_CVT_U2F, 32'd16777216, 5'd10, 32'h4B800000, 1'b0, 7);
        conv("unsup",    FPU_ADD,     32'd5,        5'd11, 32'h00000000, 1'b0, 1);

        // Backpressure: hold result while a second request waits.
        start(FPU_CVT_I2F, 32'd5, 5'd12);
        wait_out();
        chk("bp_res", result, 32'h40A00000);
        held_res = result;
        fpu_op   = FPU_CVT_I2F;
        operand  = 32'd3;
        in_tag   = 5'd13;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", result, held_res);
            chk("bp_tag", {27'd0, out_tag}, 32'd12);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        wait_out();
        chk("bp2_lat", 32'(lat), 32'd12);
        chk("bp2_res", result, 32'h40400000);
        chk("bp2_tag", {27'd0, out_tag}, 32'd13);
        handshake();

        // Reset in the middle of normalising 1.
        start(FPU_CVT_U2F, 32'd1, 5'd14);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_result", result, 32'd0);
        chk("mr_tag", {27'd0, out_tag}, 32'd0);
        chk("mr_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_rel_ready", {31'd0, in_ready}, 32'd1);
        conv("after_rst", FPU_CVT_I2F, 32'd3, 5'd15, 32'h40400000, 1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fp_int_to_float.md
# fp_int_to_float

Multi-cycle integer-to-single-precision converter for the FPU execute stage, implementing FCVT.S.W (signed) and FCVT.S.WU (unsigned). It takes a 32-bit integer operand over a valid/ready handshake and normalises it iteratively. It rounds to nearest-even and returns an IEEE-754 binary32 word with an inexact flag. It is the int→float counterpart of the FPU's float→int result paths, such as compares and FCVT.W.S, and shares the same `fpu_op_t` dispatch.

## Interface
Parameters:
- `TAG_WIDTH`, default 5: width of the opaque tag carried from input to output (warp/dest id).

Ports:
- `clk`: input, 1 bit. Clock.
- `rst`: input, 1 bit. Reset. One clock; reset is synchronous and active-high.
- `in_valid`: input, 1 bit. Request present.
- `in_ready`: output, 1 bit. Block can accept a request; high only in IDLE and not in reset.
- `operand`: input, `DATA_WIDTH` bits. Integer source.
- `fpu_op`: input, `fpu_op_t`. `FPU_CVT_I2F` (signed) or `FPU_CVT_U2F` (unsigned).
- `in_tag`: input, `TAG_WIDTH` bits. Tag captured with the request.
- `out_valid`: output, 1 bit. Result present.
- `out_ready`: input, 1 bit. Consumer accepts the result.
- `result`: output, `DATA_WIDTH` bits. binary32 result.
- `out_tag`: output, `TAG_WIDTH` bits. Tag of the current result.
- `flag_inexact`: output, 1 bit. The result was rounded (guard or sticky bit nonzero).

## Operation
- A request is accepted when `in_valid && in_ready`. On accept, the block latches `fpu_op` and `in_tag`, and latches the sign and 32-bit magnitude:
  - Signed: sign = `operand[31]`; magnitude = two's-complement absolute value. INT_MIN gives magnitude 0x80000000.
  - Unsigned: sign = 0; magnitude = `operand`.
- The working exponent loads `FP_EXP_BIAS + 31` (158).
- Any other `fpu_op` is accepted and yields `result` = 0x00000000 with `flag_inexact` = 0, via the zero path.
- FSM states are IDLE, NORM, ROUND and DONE.
  - **IDLE**: on accept, go to DONE if the magnitude is 0 or the op is unsupported; otherwise go to NORM.
  - **NORM**: one action per cycle, in priority order:
    - if `mag[31]`=1, go to ROUND with no shift;
    - else if `mag[31:28]`=0, shift left by 4 and subtract 4 from the exponent;
    - else shift left by 1 and subtract 1 from the exponent.
  - **ROUND**: sticky = OR of `mag[6:0]`. Fraction = `mag[30:8]` plus a round-up increment. Round up when guard `mag[7]`=1 and (sticky=1 or `mag[8]`=1). If the fraction carries out of 23 bits, the fraction becomes 0 and the exponent increments. Then register `result` = {sign, exp[7:0], frac}, set `flag_inexact` = guard | sticky, and go to DONE.
  - **DONE**: `out_valid`=1. On `out_ready`, go to IDLE. While `out_ready`=0, `result`, `out_tag` and `flag_inexact` hold stable.
- Overflow, NaN and denormal results cannot occur for 32-bit inputs. The maximum exponent is 159 (2^32).
- The zero path produces +0.0, including for a signed input of 0.

## Timing
- Reset (`rst`=1 at an edge): state goes to IDLE; `out_valid`=0, `result`=0, `out_tag`=0, `flag_inexact`=0. `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-operation aborts the conversion with no output, and the in-flight tag is dropped.
- The accept edge is cycle T. Latency is measured from T to the first cycle with `out_valid` high.
  - Zero or unsupported op: `out_valid` at T+1.
  - Otherwise: `out_valid` at T+3+S, where S is the number of NORM shift cycles. S = floor(lz/4) + (lz mod 4), where lz is the leading-zero count of the magnitude.
  - Range: 3 cycles (magnitude bit 31 set) to 13 cycles (magnitude 1).
- There is no overlap. `in_ready`=0 from T+1 until the cycle after output handshake completes. A new accept is possible at the earliest one cycle after the `out_valid && out_ready` edge.
- `out_valid` never drops without `out_ready`. `in_ready` does not depend combinationally on `out_ready`.

## Structure
- `pkg_opengpu` additions:
  - `FPU_CVT_I2F` and `FPU_CVT_U2F` enumerators in `fpu_op_t`;
  - `localparam FP_EXP_BIAS = 127`;
  - the FSM state enum `i2f_state_t`.
- It reuses `DATA_WIDTH`, `FP_EXP_WIDTH` and `FP_MANT_WIDTH`.
- One combinational sub-module, `fp_round_rne`, holds the ROUND logic. Input is a normalised 32-bit magnitude plus exponent. Outputs are the packed exponent/fraction and the inexact flag. The planned FP add/mul units reuse it.

## Test plan
- Signed 1 → `result` 0x3F800000, inexact 0, `out_valid` exactly 13 cycles after accept. Signed −1 → 0xBF800000. Signed 0 → 0x00000000 at T+1.
- Signed INT_MIN 0x80000000 → 0xCF000000, latency 3. Signed 0x7FFFFFFF → 0x4F000000, inexact 1.
- Unsigned 0xFFFFFFFF → 0x4F800000 (rounding carry bumps exponent to 159), inexact 1. Unsigned 0x80000000 → 0x4F000000, inexact 0.
- Ties-to-even: 16777217 → 0x4B800000 (inexact 1); 16777219 → 0x4B800002 (inexact 1); 16777216 → 0x4B800000 (inexact 0).
- Backpressure: `out_ready` held 0 for 5 cycles in DONE → `result`/`out_tag` stable, `in_ready`=0, second `in_valid` not accepted. Release → handshake, then accept on the following cycle with the new tag returned.
- Reset asserted during NORM of input 1 → next cycle `out_valid`=0 and outputs zero. `in_ready`=1 after release; the next conversion of 3 gives 0x40400000 with a correct tag.
